// File: rtl/genius_vga_pkg.sv
// Shared constants for the Genius VGA renderer: default 640x480@60 timing,
// SPRITES_FLAGS bit positions and the 12-bit {R,G,B} palette.
package genius_vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int FLAG_BLUE   = 6;
  localparam int FLAG_GREEN  = 5;
  localparam int FLAG_RED    = 4;
  localparam int FLAG_YELLOW = 3;
  localparam int FLAG_LOSE   = 2;
  localparam int FLAG_WIN    = 1;
  localparam int FLAG_PWR    = 0;

  typedef logic [11:0] rgb_t;

  localparam rgb_t BLUE_LIT   = 12'h00F;
  localparam rgb_t BLUE_DIM   = 12'h008;
  localparam rgb_t GREEN_LIT  = 12'h0F0;
  localparam rgb_t GREEN_DIM  = 12'h080;
  localparam rgb_t RED_LIT    = 12'hF00;
  localparam rgb_t RED_DIM    = 12'h800;
  localparam rgb_t YELLOW_LIT = 12'hFF0;
  localparam rgb_t YELLOW_DIM = 12'h880;
  localparam rgb_t WHITE      = 12'hFFF;
  localparam rgb_t BLACK      = 12'h000;

  // Encoded as {bottom, right} so the quadrant index falls straight out of the counters.
  typedef enum logic [1:0] {PAD_TL, PAD_TR, PAD_BL, PAD_BR} pad_e;

  function automatic rgb_t pad_colour(input pad_e pad, input logic [6:0] flags);
    case (pad)
      PAD_TL:  return flags[FLAG_BLUE]   ? BLUE_LIT   : BLUE_DIM;
      PAD_TR:  return flags[FLAG_GREEN]  ? GREEN_LIT  : GREEN_DIM;
      PAD_BL:  return flags[FLAG_RED]    ? RED_LIT    : RED_DIM;
      default: return flags[FLAG_YELLOW] ? YELLOW_LIT : YELLOW_DIM;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster counters with combinational sync/active decode
// and strobes for the first pixel and the last cycle of a frame.
module vga_timing
  import genius_vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  output logic [9:0] hcnt_o,
  output logic [9:0] vcnt_o,
  output logic       hs_n_o,
  output logic       vs_n_o,
  output logic       active_o,
  output logic       frame_start_o,
  output logic       frame_end_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       h_last, v_last;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    h_last = (hcnt_q == 10'(H_TOTAL - 1));
    v_last = (vcnt_q == 10'(V_TOTAL - 1));
    hcnt_d = h_last ? '0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 10'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o        = hcnt_q;
  assign vcnt_o        = vcnt_q;
  assign hs_n_o        = !((hcnt_q >= 10'(H_ACTIVE + H_FP)) && (hcnt_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n_o        = !((vcnt_q >= 10'(V_ACTIVE + V_FP)) && (vcnt_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
  assign active_o      = (hcnt_q < 10'(H_ACTIVE)) && (vcnt_q < 10'(V_ACTIVE));
  assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);
  assign frame_end_o   = h_last && v_last;

endmodule

// File: rtl/genius_vga_render.sv
// Genius game renderer: latches the sprite flags once per frame, runs the WIN
// blink, picks each pixel's colour and registers all VGA outputs together.
module genius_vga_render
  import genius_vga_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_FP         = H_FP_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BP         = H_BP_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_FP         = V_FP_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BP         = V_BP_DEF,
  parameter int BORDER       = 8,
  parameter int PWR_SIZE     = 32,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [6:0] SPRITES_FLAGS,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       FRAME_START
);

  localparam int HH   = H_ACTIVE / 2;
  localparam int VH   = V_ACTIVE / 2;
  localparam int HALF = PWR_SIZE / 2;
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [9:0] hcnt, vcnt;
  logic       hs_n, vs_n, active, frame_start, frame_end;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i        (CLK),
    .rst_n_i      (RESET_N),
    .hcnt_o       (hcnt),
    .vcnt_o       (vcnt),
    .hs_n_o       (hs_n),
    .vs_n_o       (vs_n),
    .active_o     (active),
    .frame_start_o(frame_start),
    .frame_end_o  (frame_end)
  );

  logic [6:0]    flags_q, flags_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    flags_d     = flags_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (frame_end) flags_d = SPRITES_FLAGS;
    // The blink phase restarts whenever WIN is not on screen, so every win shows green first.
    if (!flags_q[FLAG_WIN]) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = !blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  logic left, top, in_pad_x, in_pad_y, in_pwr;
  pad_e pad;
  rgb_t rgb_d;

  always_comb begin
    left     = hcnt < 10'(HH);
    top      = vcnt < 10'(VH);
    pad      = pad_e'({!top, !left});
    in_pad_x = left ? (hcnt >= 10'(BORDER) && hcnt < 10'(HH - BORDER))
                    : (hcnt >= 10'(HH + BORDER) && hcnt < 10'(H_ACTIVE - BORDER));
    in_pad_y = top  ? (vcnt >= 10'(BORDER) && vcnt < 10'(VH - BORDER))
                    : (vcnt >= 10'(VH + BORDER) && vcnt < 10'(V_ACTIVE - BORDER));
    in_pwr   = (hcnt > 10'(HH - HALF)) && (hcnt < 10'(HH + HALF)) &&
               (vcnt > 10'(VH - HALF)) && (vcnt < 10'(VH + HALF));
    rgb_d    = BLACK;
    if (active) begin
      if (flags_q[FLAG_LOSE])         rgb_d = RED_LIT;
      else if (flags_q[FLAG_WIN])     rgb_d = blink_q ? BLACK : GREEN_LIT;
      else if (!flags_q[FLAG_PWR])    rgb_d = BLACK;
      else if (in_pwr)                rgb_d = WHITE;
      else if (in_pad_x && in_pad_y)  rgb_d = pad_colour(pad, flags_q);
    end
  end

  logic hs_q, vs_q, blank_n_q, frame_start_q;
  rgb_t rgb_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flags_q       <= '0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= BLACK;
      frame_start_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
      hs_q          <= hs_n;
      vs_q          <= vs_n;
      blank_n_q     <= active;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start;
    end
  end

  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign FRAME_START = frame_start_q;

endmodule
